mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one downstream memory bus between the instruction-fetch requester (read-only) and the load/store requester (read/write).
- Sequences each transfer: grant → bus request handshake → response wait → completion pulse.
- Produces the per-requester stall levels consumed by the pipeline stall/flush controller.
- Sits between IF/MEM stages and the bus bridge; the watchdog converts a hung bus into an error completion.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data width; must be a multiple of 8
TIMEOUT_CYC, 255, max cycles in REQ or RESP before forced error completion; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
if_req_i  in  1  IF read request; held with if_addr_i until if_done_o
if_addr_i  in  ADDR_W  IF address
if_rdata_o  out  DATA_W  IF read data; valid with if_done_o
if_done_o  out  1  IF completion, one-cycle pulse
if_err_o  out  1  IF error; valid with if_done_o
mem_req_i  in  1  LSU request; held with payload until mem_done_o
mem_we_i  in  1  1 = write
mem_addr_i  in  ADDR_W  LSU address
mem_wdata_i  in  DATA_W  write data
mem_wstrb_i  in  DATA_W/8  byte strobes
mem_rdata_o  out  DATA_W  LSU read data; valid with mem_done_o
mem_done_o  out  1  LSU completion, one-cycle pulse
mem_err_o  out  1  LSU error; valid with mem_done_o
bus_req_valid_o  out  1  downstream request valid
bus_req_ready_i  in  1  downstream request accepted
bus_we_o  out  1  write
bus_addr_o  out  ADDR_W  address
bus_wdata_o  out  DATA_W  write data
bus_wstrb_o  out  DATA_W/8  strobes
bus_resp_valid_i  in  1  response valid
bus_rdata_i  in  DATA_W  response data
bus_err_i  in  1  response error
ram_stall_valid_if_o  out  1  IF stall level
ram_stall_valid_mem_o  out  1  LSU stall level

Behaviour:
- States: IDLE, REQ, RESP, DONE.
- Reset (asynchronous, any state):
  - state = IDLE; all outputs 0, including bus_req_valid_o (drops immediately); counter = 0; owner = IF.
- IDLE:
  - Only mem_req_i → owner MEM. Only if_req_i → owner IF.
  - Both → arbitration policy (see Optional Feature).
  - On grant: latch owner payload into bus_* registers (IF: we=0, wstrb=0), go to REQ.
  - No request → stay IDLE.
- REQ:
  - bus_req_valid_o = 1; payload stable.
  - bus_req_ready_i = 1 → RESP; bus_req_valid_o deasserts next cycle.
- RESP:
  - bus_resp_valid_i = 1 → capture bus_rdata_i and bus_err_i into the owner's rdata/err registers → DONE.
  - bus_resp_valid_i in the same cycle as ready (still in REQ) is ignored; the bus delivers the response at least one cycle after acceptance.
- DONE:
  - Owner's done = 1 for exactly one cycle → IDLE.
  - Requests sampled during DONE are ignored; the requester still holds the completed request that cycle.
- Latency: with ready and resp_valid each high at first opportunity, done asserts 3 cycles after req is first seen in IDLE.
- rdata/err outputs hold their last value until the next completion for that requester. Writes return bus_rdata_i unchanged (don't-care).
- Stalls (combinational):
  - ram_stall_valid_if_o = if_req_i & ~if_done_o.
  - ram_stall_valid_mem_o = mem_req_i & ~mem_done_o.
  - The losing requester stays stalled through the winner's transfer.
- Watchdog:
  - Counter clears on entry to REQ and on entry to RESP; increments each cycle in those states.
  - Reaching TIMEOUT_CYC → DONE with err = 1, rdata = 0.
  - A late bus_resp_valid_i arriving in IDLE/REQ is discarded.
- Requests are level-sensitive; dropping req mid-transfer does not abort the transfer, and done still pulses.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: 1-bit last-grant register (reset = IF). On simultaneous requests in IDLE, grant the requester not granted last, so MEM wins first after reset; last-grant updates on every grant.
- Undefined: fixed priority, MEM always wins on simultaneous requests; no last-grant register.

Test Plan:
- IF read, addr 0x8000_0000, ready and resp same-latency, rdata 0x1122334455667788 → if_done_o 3 cycles after request with that data, err 0; ram_stall_valid_if_o high for exactly those 3 cycles.
- LSU write, addr 0x8000_0100, wdata 0xDEAD, wstrb 0x03, ready delayed 4 cycles → bus_req_valid_o held 5 cycles with stable payload; bus_we_o = 1; mem_done_o pulses once.
- Simultaneous IF and MEM requests, back to back:
  - Without macro: MEM served, then IF; IF stall stays high throughout.
  - With macro: MEM then IF, and on the next simultaneous pair IF goes first.
- TIMEOUT_CYC = 8, bus never responds after ready → mem_done_o with mem_err_o = 1 and rdata = 0, 10 cycles after grant; a later bus_resp_valid_i is ignored.
- rst asserted while in RESP → bus_req_valid_o, done, and stalls drop asynchronously; after release a fresh IF request completes normally.
- bus_err_i = 1 on an IF response → if_err_o = 1 with if_done_o; the next IF transfer without error returns err 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory bus between the instruction-fetch
// requester (read-only) and the load/store requester (read/write).
// Each transfer runs IDLE -> REQ -> RESP -> DONE. A watchdog turns a hung bus into
// an error completion.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When defined, simultaneous requests
// alternate between the two requesters. When undefined, MEM has fixed priority.

module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_done_o,
  output logic                if_err_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_done_o,
  output logic                mem_err_o,
  output logic                bus_req_valid_o,
  input  logic                bus_req_ready_i,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  input  logic                bus_resp_valid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_err_i,
  output logic                ram_stall_valid_if_o,
  output logic                ram_stall_valid_mem_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic OwnerIf  = 1'b0;
  localparam logic OwnerMem = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0] bus_wstrb_q, bus_wstrb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_err_q, if_err_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              mem_err_q, mem_err_d;

  logic              any_req;
  logic              prio_mem;
  logic              grant_mem;
  logic              timeout;
  logic              cap_en;
  logic [DATA_W-1:0] cap_data;
  logic              cap_err;

  assign any_req = if_req_i | mem_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  // Tracks which requester won the previous grant, so ties alternate.
  logic last_q, last_d;

  // Record the winner on every grant.
  always_comb begin
    last_d = last_q;
    if (state_q == StIdle && any_req) begin
      last_d = grant_mem ? OwnerMem : OwnerIf;
    end
  end

  // Last-grant register; starts at IF so MEM wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OwnerIf;
    end else begin
      last_q <= last_d;
    end
  end

  assign prio_mem = (last_q == OwnerIf);
`else
  assign prio_mem = 1'b1;
`endif

  assign grant_mem = mem_req_i & (~if_req_i | prio_mem);

  // The watchdog fires on the last permitted cycle in REQ or RESP.
  assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Next-state, payload latch, watchdog counter and completion capture.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    cnt_d       = cnt_q;
    cap_en      = 1'b0;
    cap_data    = '0;
    cap_err     = 1'b0;

    case (state_q)
      StIdle: begin
        if (any_req) begin
          cnt_d = '0;
          state_d = StReq;
          if (grant_mem) begin
            owner_d     = OwnerMem;
            bus_we_d    = mem_we_i;
            bus_addr_d  = mem_addr_i;
            bus_wdata_d = mem_wdata_i;
            bus_wstrb_d = mem_wstrb_i;
          end else begin
            owner_d     = OwnerIf;
            bus_we_d    = 1'b0;
            bus_addr_d  = if_addr_i;
            bus_wdata_d = '0;
            bus_wstrb_d = '0;
          end
        end
      end
      StReq: begin
        if (bus_req_ready_i) begin
          cnt_d   = '0;
          state_d = StResp;
        end else if (timeout) begin
          cap_en  = 1'b1;
          cap_err = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StResp: begin
        if (bus_resp_valid_i) begin
          cap_en   = 1'b1;
          cap_data = bus_rdata_i;
          cap_err  = bus_err_i;
          state_d  = StDone;
        end else if (timeout) begin
          cap_en  = 1'b1;
          cap_err = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // DONE: requests seen here belong to the transfer just completed.
        state_d = StIdle;
      end
    endcase
  end

  // Route a captured completion to the owning requester's result registers.
  always_comb begin
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    mem_rdata_d = mem_rdata_q;
    mem_err_d   = mem_err_q;
    if (cap_en) begin
      if (owner_q == OwnerMem) begin
        mem_rdata_d = cap_data;
        mem_err_d   = cap_err;
      end else begin
        if_rdata_d = cap_data;
        if_err_d   = cap_err;
      end
    end
  end

  // State, bus payload and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnerIf;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      cnt_q       <= '0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      mem_rdata_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      cnt_q       <= cnt_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      mem_rdata_q <= mem_rdata_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // Outputs decoded from state. Stalls are gated by rst so they drop with it.
  always_comb begin
    bus_req_valid_o       = (state_q == StReq);
    bus_we_o              = bus_we_q;
    bus_addr_o            = bus_addr_q;
    bus_wdata_o           = bus_wdata_q;
    bus_wstrb_o           = bus_wstrb_q;
    if_done_o             = (state_q == StDone) && (owner_q == OwnerIf);
    mem_done_o            = (state_q == StDone) && (owner_q == OwnerMem);
    if_rdata_o            = if_rdata_q;
    if_err_o              = if_err_q;
    mem_rdata_o           = mem_rdata_q;
    mem_err_o             = mem_err_q;
    ram_stall_valid_if_o  = ~rst & if_req_i & ~if_done_o;
    ram_stall_valid_mem_o = ~rst & mem_req_i & ~mem_done_o;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter, built with TIMEOUT_CYC = 8.
// Expectations follow ARB_ROUND_ROBIN_EN when the bench is built with that macro.

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [63:0] if_rdata_o;
  logic        if_done_o;
  logic        if_err_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [63:0] mem_wdata_i;
  logic [7:0]  mem_wstrb_i;
  logic [63:0] mem_rdata_o;
  logic        mem_done_o;
  logic        mem_err_o;
  logic        bus_req_valid_o;
  logic        bus_req_ready_i;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [63:0] bus_wdata_o;
  logic [7:0]  bus_wstrb_o;
  logic        bus_resp_valid_i;
  logic [63:0] bus_rdata_i;
  logic        bus_err_i;
  logic        ram_stall_valid_if_o;
  logic        ram_stall_valid_mem_o;

  int n_chk  = 0;
  int n_pass = 0;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (64),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .if_req_i              (if_req_i),
    .if_addr_i             (if_addr_i),
    .if_rdata_o            (if_rdata_o),
    .if_done_o             (if_done_o),
    .if_err_o              (if_err_o),
    .mem_req_i             (mem_req_i),
    .mem_we_i              (mem_we_i),
    .mem_addr_i            (mem_addr_i),
    .mem_wdata_i           (mem_wdata_i),
    .mem_wstrb_i           (mem_wstrb_i),
    .mem_rdata_o           (mem_rdata_o),
    .mem_done_o            (mem_done_o),
    .mem_err_o             (mem_err_o),
    .bus_req_valid_o       (bus_req_valid_o),
    .bus_req_ready_i       (bus_req_ready_i),
    .bus_we_o              (bus_we_o),
    .bus_addr_o            (bus_addr_o),
    .bus_wdata_o           (bus_wdata_o),
    .bus_wstrb_o           (bus_wstrb_o),
    .bus_resp_valid_i      (bus_resp_valid_i),
    .bus_rdata_i           (bus_rdata_i),
    .bus_err_i             (bus_err_i),
    .ram_stall_valid_if_o  (ram_stall_valid_if_o),
    .ram_stall_valid_mem_o (ram_stall_valid_mem_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle with the request already driven; ends in the DONE cycle.
  // A spurious response is offered alongside ready and must be ignored.
  task automatic xfer(input string tag, input logic [31:0] exp_addr, input logic exp_we,
                      input logic is_mem, input logic [63:0] rd, input logic er);
    tick();
    bus_req_ready_i  = 1'b1;
    bus_resp_valid_i = 1'b1;
    bus_rdata_i      = 64'hBAD0_BAD0_BAD0_BAD0;
    bus_err_i        = 1'b1;
    #1;
    chk({tag, "_req_valid"}, 64'(bus_req_valid_o), 64'd1);
    chk({tag, "_addr"}, 64'(bus_addr_o), 64'(exp_addr));
    chk({tag, "_we"}, 64'(bus_we_o), 64'(exp_we));
    if (!is_mem) chk({tag, "_stall_if_req"}, 64'(ram_stall_valid_if_o), 64'd1);
    tick();
    bus_req_ready_i  = 1'b0;
    bus_resp_valid_i = 1'b1;
    bus_rdata_i      = rd;
    bus_err_i        = er;
    #1;
    chk({tag, "_valid_drop"}, 64'(bus_req_valid_o), 64'd0);
    if (!is_mem) chk({tag, "_stall_if_resp"}, 64'(ram_stall_valid_if_o), 64'd1);
    tick();
    bus_resp_valid_i = 1'b0;
    bus_err_i        = 1'b0;
    #1;
    if (is_mem) begin
      chk({tag, "_mem_done"}, 64'(mem_done_o), 64'd1);
      chk({tag, "_if_done"}, 64'(if_done_o), 64'd0);
      chk({tag, "_mem_rdata"}, mem_rdata_o, rd);
      chk({tag, "_mem_err"}, 64'(mem_err_o), 64'(er));
    end else begin
      chk({tag, "_if_done"}, 64'(if_done_o), 64'd1);
      chk({tag, "_mem_done"}, 64'(mem_done_o), 64'd0);
      chk({tag, "_if_rdata"}, if_rdata_o, rd);
      chk({tag, "_if_err"}, 64'(if_err_o), 64'(er));
      chk({tag, "_stall_if_done"}, 64'(ram_stall_valid_if_o), 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0;
    bus_req_ready_i = 1'b0; bus_resp_valid_i = 1'b0; bus_rdata_i = '0; bus_err_i = 1'b0;
    #1;
    chk("rst_valid", 64'(bus_req_valid_o), 64'd0);
    chk("rst_addr", 64'(bus_addr_o), 64'd0);
    chk("rst_done", 64'({if_done_o, mem_done_o}), 64'd0);
    chk("rst_rdata", if_rdata_o | mem_rdata_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    // IF read, 3-cycle latency.
    if_req_i = 1'b1; if_addr_i = 32'h8000_0000;
    #1;
    chk("t1_stall_if_idle", 64'(ram_stall_valid_if_o), 64'd1);
    chk("t1_valid_idle", 64'(bus_req_valid_o), 64'd0);
    xfer("t1", 32'h8000_0000, 1'b0, 1'b0, 64'h1122_3344_5566_7788, 1'b0);
    tick();
    if_req_i = 1'b0;
    #1;
    chk("t1_done_once", 64'(if_done_o), 64'd0);
    chk("t1_rdata_hold", if_rdata_o, 64'h1122_3344_5566_7788);

    // LSU write with ready delayed 4 cycles.
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h8000_0100;
    mem_wdata_i = 64'hDEAD; mem_wstrb_i = 8'h03;
    #1;
    chk("t2_stall_mem_idle", 64'(ram_stall_valid_mem_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      bus_req_ready_i = (i == 4);
      #1;
      chk("t2_valid", 64'(bus_req_valid_o), 64'd1);
      chk("t2_payload", {bus_we_o, bus_wstrb_o, bus_addr_o[15:0], bus_wdata_o[38:0]},
          {1'b1, 8'h03, 16'h0100, 39'hDEAD});
      chk("t2_stall_mem", 64'(ram_stall_valid_mem_o), 64'd1);
    end
    tick();
    bus_req_ready_i = 1'b0; bus_resp_valid_i = 1'b1; bus_rdata_i = 64'h5555;
    #1;
    chk("t2_valid_drop", 64'(bus_req_valid_o), 64'd0);
    tick();
    bus_resp_valid_i = 1'b0;
    #1;
    chk("t2_mem_done", 64'(mem_done_o), 64'd1);
    chk("t2_mem_err", 64'(mem_err_o), 64'd0);
    chk("t2_stall_mem_done", 64'(ram_stall_valid_mem_o), 64'd0);
    tick();
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_wstrb_i = '0; mem_wdata_i = '0;
    #1;
    chk("t2_done_once", 64'(mem_done_o), 64'd0);

    // Reset while in REQ: valid drops without a clock edge.
    if_req_i = 1'b1; if_addr_i = 32'h100;
    tick();
    #1;
    chk("rreq_valid", 64'(bus_req_valid_o), 64'd1);
    #2;
    rst = 1'b1; if_req_i = 1'b0;
    #1;
    chk("rreq_valid_async", 64'(bus_req_valid_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Simultaneous requests; MEM re-requests right after its first completion.
    if_req_i = 1'b1; if_addr_i = 32'h300;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h200;
    #1;
    chk("s_stall_both", 64'({ram_stall_valid_if_o, ram_stall_valid_mem_o}), 64'd3);
    xfer("s1", 32'h200, 1'b0, 1'b1, 64'hA1, 1'b0);
    chk("s1_stall_if", 64'(ram_stall_valid_if_o), 64'd1);
    tick();
    mem_addr_i = 32'h210;
    #1;
`ifdef ARB_ROUND_ROBIN_EN
    xfer("s2", 32'h300, 1'b0, 1'b0, 64'hA2, 1'b0);
    tick();
    if_req_i = 1'b0;
    #1;
    xfer("s3", 32'h210, 1'b0, 1'b1, 64'hA3, 1'b0);
    tick();
    mem_req_i = 1'b0;
`else
    xfer("s2", 32'h210, 1'b0, 1'b1, 64'hA3, 1'b0);
    chk("s2_stall_if", 64'(ram_stall_valid_if_o), 64'd1);
    tick();
    mem_req_i = 1'b0;
    #1;
    xfer("s3", 32'h300, 1'b0, 1'b0, 64'hA2, 1'b0);
    tick();
    if_req_i = 1'b0;
`endif
    #1;

    // Watchdog: accepted but never answered.
    mem_req_i = 1'b1; mem_addr_i = 32'h400; bus_req_ready_i = 1'b1;
    tick();
    #1;
    chk("wd_valid", 64'(bus_req_valid_o), 64'd1);
    tick();
    bus_req_ready_i = 1'b0;
    #1;
    chk("wd_resp_done", 64'(mem_done_o), 64'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("wd_wait_done", 64'(mem_done_o), 64'd0);
    end
    tick();
    chk("wd_done", 64'(mem_done_o), 64'd1);
    chk("wd_err", 64'(mem_err_o), 64'd1);
    chk("wd_rdata", mem_rdata_o, 64'd0);
    tick();
    mem_req_i = 1'b0; bus_resp_valid_i = 1'b1; bus_rdata_i = 64'hFFFF; bus_err_i = 1'b0;
    tick();
    bus_resp_valid_i = 1'b0;
    #1;
    chk("wd_late_done", 64'(mem_done_o), 64'd0);
    chk("wd_late_rdata", mem_rdata_o, 64'd0);
    chk("wd_late_err", 64'(mem_err_o), 64'd1);
    chk("wd_late_valid", 64'(bus_req_valid_o), 64'd0);

    // Reset while in RESP, then a fresh IF request.
    if_req_i = 1'b1; if_addr_i = 32'h500;
    tick();
    bus_req_ready_i = 1'b1;
    tick();
    bus_req_ready_i = 1'b0;
    #1;
    chk("rresp_stall_pre", 64'(ram_stall_valid_if_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rresp_valid", 64'(bus_req_valid_o), 64'd0);
    chk("rresp_done", 64'({if_done_o, mem_done_o}), 64'd0);
    chk("rresp_stall", 64'(ram_stall_valid_if_o), 64'd0);
    chk("rresp_rdata", if_rdata_o, 64'd0);
    if_addr_i = 32'h600;
    @(negedge clk);
    rst = 1'b0;
    xfer("rfresh", 32'h600, 1'b0, 1'b0, 64'hCAFE, 1'b0);

    // Bus error on an IF response, then a clean one.
    tick();
    if_addr_i = 32'h700;
    xfer("err1", 32'h700, 1'b0, 1'b0, 64'h77, 1'b1);
    tick();
    if_addr_i = 32'h708;
    xfer("err0", 32'h708, 1'b0, 1'b0, 64'h78, 1'b0);
    tick();
    if_req_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
